// File: rtl/io_bus_ctrl_pkg.sv
// rtl/io_bus_ctrl_pkg.sv - shared constants for the io_bus_ctrl register window
package io_bus_ctrl_pkg;

    localparam logic [15:0] IO_BASE_DEF = 16'hFF00;
    localparam int          FIFO_AW_DEF = 2;

    localparam logic [3:0] OFF_OUT0    = 4'h0;
    localparam logic [3:0] OFF_OUT1    = 4'h1;
    localparam logic [3:0] OFF_IN0     = 4'h2;
    localparam logic [3:0] OFF_IN1     = 4'h3;
    localparam logic [3:0] OFF_EDGE    = 4'h4;
    localparam logic [3:0] OFF_EDGE_EN = 4'h5;
    localparam logic [3:0] OFF_TXDATA  = 4'h6;
    localparam logic [3:0] OFF_STATUS  = 4'h7;

    localparam int ST_OVF   = 15;
    localparam int ST_FULL  = 3;
    localparam int ST_EMPTY = 2;

    // STATUS only has two count bits, so a full FIFO reports 3 there
    function automatic logic [1:0] sat_count(input logic [7:0] cnt);
        return (cnt > 8'd3) ? 2'd3 : cnt[1:0];
    endfunction

endpackage

// File: rtl/io_bus_ctrl_tx_fifo.sv
// rtl/io_bus_ctrl_tx_fifo.sv - synchronous transmit FIFO with sticky overflow flag
module io_bus_ctrl_tx_fifo #(
    parameter int AW = 2,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_ready,
    input  logic          i_ovf_clr,
    output logic [W-1:0]  o_data,
    output logic          o_valid,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          w_pop;
    logic          w_wr;

    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_valid = ~o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_ovf   = r_ovf;

    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign w_pop = o_valid & i_ready;
    assign w_wr  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && o_full && !w_pop) r_ovf <= 1'b1;
            else if (i_ovf_clr)             r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - memory-mapped I/O window: port registers, input syncs, edge irq, TX FIFO
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter int          FIFO_AW = FIFO_AW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        oe,
    input  logic [15:0] Direcciones,
    inout  wire  [15:0] Datos,
    input  logic [15:0] port_in0,
    input  logic [15:0] port_in1,
    output logic [15:0] port_out0,
    output logic [15:0] port_out1,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    logic              w_hit, w_wr_hit, w_rd_hit;
    logic [3:0]        w_off;
    logic [15:0]       w_wdata, w_rdata, w_edge_clr, w_rise;
    logic              w_tx_wr, w_push, w_ovf_clr;
    logic [FIFO_AW:0]  w_count;
    logic              w_full, w_empty, w_ovf;

    logic [15:0] r_out0, r_out1, r_edge, r_edge_en;
    logic [15:0] r_s0_1, r_s0_2, r_s0_3, r_s1_1, r_s1_2;
    logic        r_tx_wr_q;

    assign w_hit    = (Direcciones[15:4] == IO_BASE[15:4]);
    assign w_wr_hit = oe & w_hit;
    assign w_rd_hit = ~oe & w_hit;
    assign w_off    = Direcciones[3:0];
    assign w_wdata  = Datos;

    // A held TXDATA write pushes only on its first cycle
    assign w_tx_wr    = w_wr_hit && (w_off == OFF_TXDATA);
    assign w_push     = w_tx_wr & ~r_tx_wr_q;
    assign w_ovf_clr  = w_wr_hit && (w_off == OFF_STATUS) && w_wdata[ST_OVF];
    assign w_edge_clr = (w_wr_hit && (w_off == OFF_EDGE)) ? w_wdata : 16'h0000;
    assign w_rise     = r_s0_2 & ~r_s0_3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out0    <= '0;
            r_out1    <= '0;
            r_edge    <= '0;
            r_edge_en <= '0;
            r_s0_1    <= '0;
            r_s0_2    <= '0;
            r_s0_3    <= '0;
            r_s1_1    <= '0;
            r_s1_2    <= '0;
            r_tx_wr_q <= 1'b0;
        end else begin
            r_s0_1    <= port_in0;
            r_s0_2    <= r_s0_1;
            r_s0_3    <= r_s0_2;
            r_s1_1    <= port_in1;
            r_s1_2    <= r_s1_1;
            r_tx_wr_q <= w_tx_wr;
            r_edge    <= (r_edge & ~w_edge_clr) | w_rise;
            if (w_wr_hit && w_off == OFF_OUT0)    r_out0    <= w_wdata;
            if (w_wr_hit && w_off == OFF_OUT1)    r_out1    <= w_wdata;
            if (w_wr_hit && w_off == OFF_EDGE_EN) r_edge_en <= w_wdata;
        end
    end

    io_bus_ctrl_tx_fifo #(.AW(FIFO_AW), .W(16)) u_tx_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .i_push     (w_push),
        .i_push_data(w_wdata),
        .i_ready    (tx_ready),
        .i_ovf_clr  (w_ovf_clr),
        .o_data     (tx_data),
        .o_valid    (tx_valid),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_ovf      (w_ovf)
    );

    always_comb begin
        w_rdata = 16'h0000;
        case (w_off)
            OFF_OUT0:    w_rdata = r_out0;
            OFF_OUT1:    w_rdata = r_out1;
            OFF_IN0:     w_rdata = r_s0_2;
            OFF_IN1:     w_rdata = r_s1_2;
            OFF_EDGE:    w_rdata = r_edge;
            OFF_EDGE_EN: w_rdata = r_edge_en;
            OFF_STATUS: begin
                w_rdata[ST_OVF]   = w_ovf;
                w_rdata[ST_FULL]  = w_full;
                w_rdata[ST_EMPTY] = w_empty;
                w_rdata[1:0]      = sat_count(8'(w_count));
            end
            default:     w_rdata = 16'h0000;
        endcase
    end

    assign Datos     = w_rd_hit ? w_rdata : {16{1'bz}};
    assign port_out0 = r_out0;
    assign port_out1 = r_out1;
    assign irq       = |(r_edge & r_edge_en);

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - scoreboard bench for io_bus_ctrl
module tb_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        oe;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] port_in0, port_in1;
    logic [15:0] port_out0, port_out1, tx_data;
    logic        tx_valid, tx_ready, irq;
    tri1  [15:0] Datos;

    assign Datos = oe ? wd : 16'hzzzz;

    io_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .oe         (oe),
        .Direcciones(addr),
        .Datos      (Datos),
        .port_in0   (port_in0),
        .port_in1   (port_in1),
        .port_out0  (port_out0),
        .port_out1  (port_out1),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        probe_req = 1'b0;
    int          q_sel[$];
    logic [15:0] q_exp[$];
    string       q_name[$];
    logic [15:0] tx_q[$];

    // Monitor: compares whatever the stimulus queued against what the DUT shows
    always @(negedge clk) begin
        logic [15:0] act, exp_v;
        int          sel;
        string       nm;
        if (probe_req) begin
            if (q_sel.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL probe_queue_underflow");
            end else begin
                sel = q_sel.pop_front(); exp_v = q_exp.pop_front(); nm = q_name.pop_front();
                case (sel)
                    0: act = Datos;
                    1: act = port_out0;
                    2: act = port_out1;
                    3: act = {15'b0, tx_valid};
                    default: act = {15'b0, irq};
                endcase
                n_checks++;
                if (act !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", nm, act, exp_v);
                end
            end
        end
        if (tx_valid && tx_ready) begin
            n_checks++;
            if (tx_q.size() == 0) begin
                n_errors++;
                $display("FAIL tx_unexpected: got %h expected nothing", tx_data);
            end else begin
                exp_v = tx_q.pop_front();
                if (tx_data !== exp_v) begin
                    n_errors++;
                    $display("FAIL tx_pop: got %h expected %h", tx_data, exp_v);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int sel, input logic [15:0] e, input string nm);
        q_sel.push_back(sel); q_exp.push_back(e); q_name.push_back(nm);
        probe_req = 1'b1;
        cyc(1);
        probe_req = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        oe = 1'b0; addr = a;
        probe(0, e, nm);
        addr = 16'h0000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input int n);
        oe = 1'b1; addr = a; wd = d;
        cyc(n);
        oe = 1'b0; addr = 16'h0000;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; oe = 1'b0; addr = 16'h0000; wd = 16'h0000;
        port_in0 = 16'h0000; port_in1 = 16'h0000; tx_ready = 1'b0;
        cyc(3);
        reset = 1'b1;
        probe(1, 16'h0000, "rst_out0");
        probe(2, 16'h0000, "rst_out1");
        probe(3, 16'h0000, "rst_txvalid");
        probe(4, 16'h0000, "rst_irq");
        rd(16'hFF07, 16'h0004, "rst_status");
        rd(16'h0000, 16'hFFFF, "idle_z");

        wr(16'hFF00, 16'hA5A5, 1);
        rd(16'hFF00, 16'hA5A5, "out0_read");
        probe(1, 16'hA5A5, "out0_port");
        rd(16'h1234, 16'hFFFF, "outside_z");
        wr(16'hFF01, 16'h5A5A, 1);
        rd(16'hFF01, 16'h5A5A, "out1_read");
        wr(16'hFF09, 16'hFFFF, 1);
        rd(16'hFF09, 16'h0000, "reserved_read");

        wr(16'hFF05, 16'h0001, 1);
        port_in0 = 16'h0001; port_in1 = 16'hBEEF;
        cyc(4);
        rd(16'hFF02, 16'h0001, "in0_sync");
        rd(16'hFF03, 16'hBEEF, "in1_sync");
        rd(16'hFF04, 16'h0001, "edge_set");
        probe(4, 16'h0001, "irq_set");
        wr(16'hFF04, 16'h0001, 1);
        rd(16'hFF04, 16'h0000, "edge_clr");
        probe(4, 16'h0000, "irq_clr");

        for (int i = 1; i <= 5; i++) begin
            wr(16'hFF06, 16'(i), 1);
            if (i <= 4) tx_q.push_back(16'(i));
        end
        rd(16'hFF07, 16'h800B, "status_full_ovf");
        probe(3, 16'h0001, "txvalid_full");
        tx_ready = 1'b1; cyc(4); tx_ready = 1'b0;
        rd(16'hFF07, 16'h8004, "status_drained");
        wr(16'hFF07, 16'h8000, 1);
        rd(16'hFF07, 16'h0004, "status_ovf_clr");

        wr(16'hFF06, 16'h0077, 3);
        tx_q.push_back(16'h0077);
        rd(16'hFF07, 16'h0001, "held_one_push");
        tx_ready = 1'b1; cyc(1); tx_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wr(16'hFF06, 16'h0010 + 16'(i), 1);
            tx_q.push_back(16'h0010 + 16'(i));
        end
        tx_ready = 1'b1; oe = 1'b1; addr = 16'hFF06; wd = 16'h0014;
        tx_q.push_back(16'h0014);
        cyc(1);
        tx_ready = 1'b0; oe = 1'b0; addr = 16'h0000;
        cyc(1);
        rd(16'hFF07, 16'h000B, "full_push_pop");
        tx_ready = 1'b1; cyc(4); tx_ready = 1'b0;
        rd(16'hFF07, 16'h0004, "full_push_pop_drained");

        wr(16'hFF06, 16'h0055, 1);
        wr(16'hFF00, 16'h1234, 1);
        port_in0 = 16'h0000; cyc(4);
        port_in0 = 16'h0001; cyc(4);
        probe(4, 16'h0001, "pre_reset_irq");
        probe(3, 16'h0001, "pre_reset_txvalid");
        reset = 1'b0;
        probe(1, 16'h0000, "midrst_out0");
        probe(2, 16'h0000, "midrst_out1");
        probe(3, 16'h0000, "midrst_txvalid");
        probe(4, 16'h0000, "midrst_irq");
        rd(16'hFF00, 16'h0000, "midrst_out0_read");
        rd(16'h0000, 16'hFFFF, "midrst_z");
        reset = 1'b1;
        cyc(2);

        n_checks++;
        if (tx_q.size() != 0 || q_sel.size() != 0) begin
            n_errors++;
            $display("FAIL queues_drained: got tx=%0d probe=%0d expected 0", tx_q.size(), q_sel.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
